sram_port_responder: RTL
========================

Name: sram_port_responder

Overview:
- Synthesizable responder (slave) for the tester/SOPC SRAM master port: address, byteenable, read, write, writedata, readdata, readdataready, waitrequest.
- Backs the port with an on-chip memory and inserts configurable wait states and read latency.
- Substitutes for sram_arb_sync plus the external SRAM, so the tester can run standalone and in simulation.

Parameters:
ADDR_WIDTH, 20, master address width
DATA_WIDTH, 16, data width; must be a multiple of 8
MEM_AWIDTH, 10, on-chip memory depth is 2**MEM_AWIDTH words
WAIT_CYCLES, 2, waitrequest-high cycles per transfer (0..15)
READ_LATENCY, 1, cycles from read acceptance edge to readdataready (1..4)

Ports:
clock  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_WIDTH  word address
byteenable  in  DATA_WIDTH/8  byte lane enables; bit i enables writedata[8i+7:8i]
read  in  1  read request, held until accepted
write  in  1  write request, held until accepted
writedata  in  DATA_WIDTH  write data
readdata  out  DATA_WIDTH  read data, valid only while readdataready is high
readdataready  out  1  one-cycle read data strobe
waitrequest  out  1  stall; a request is accepted on a cycle with (read|write) and !waitrequest
xfer_count  out  16  saturating count of accepted transfers
protocol_err  out  1  sticky: read and write asserted together

Behaviour:
- Reset (async, reset_n low):
  - waitrequest=1 (combinational from reset_n).
  - readdata=0, readdataready=0, xfer_count=0, protocol_err=0.
  - Wait counter=0; latency pipeline cleared.
  - Memory contents are not reset.
- Wait counter (4 bits):
  - waitrequest = !reset_n | ((read|write) & (wcnt != WAIT_CYCLES)).
  - A pending, stalled request increments wcnt each cycle.
  - On acceptance, wcnt clears to 0.
  - If the request drops before acceptance, wcnt clears to 0 and no transfer occurs.
  - Every transfer therefore occupies WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, waitrequest stays low outside reset and back-to-back transfers run at one per cycle.
- Addressing:
  - address, byteenable and writedata are sampled only on the acceptance cycle; changes during the stall are ignored.
  - Memory index = address[MEM_AWIDTH-1:0]. Upper bits are ignored, so addresses wrap modulo depth.
- Write acceptance:
  - At the acceptance edge, each byte lane with byteenable=1 is updated; other lanes keep their contents.
  - byteenable=0 still counts as an accepted transfer.
- Read acceptance:
  - The word is read at the acceptance edge, ignoring byteenable.
  - Pipeline: READ_LATENCY stages, each holding a valid bit plus data.
  - readdataready is high for exactly one cycle, READ_LATENCY cycles after the acceptance edge; readdata carries the word in that cycle.
  - Outside strobe cycles, readdata returns to 0.
  - Back-to-back reads produce back-to-back strobes in acceptance order; the pipeline never stalls.
- Read-after-write:
  - A read accepted any cycle after a write to the same index returns the new data.
  - A read and a write never share an acceptance cycle.
- Simultaneous read and write:
  - The write is performed and the read ignored.
  - protocol_err sets and stays set until reset.
  - The cycle counts as one transfer.
- xfer_count: increments by 1 per accepted transfer and saturates at 16'hFFFF.
- Reset mid-operation: any in-flight read strobe is lost. No readdataready is issued after reset releases unless a new read is accepted.

Test Plan:
1. Reset then idle, WAIT_CYCLES=2 -> during reset waitrequest=1 and all other outputs 0; after release with no request, waitrequest=0.
2. Write 16'hBEEF at address 5 with byteenable=2'b11 (WAIT_CYCLES=2) -> waitrequest high 2 cycles, accepted on 3rd; then read address 5 -> readdataready one cycle, READ_LATENCY=1 after acceptance, readdata=16'hBEEF; xfer_count=2.
3. Write 16'h1234 at address 7, then byte write 16'hAB00 with byteenable=2'b10 at address 7 -> read returns 16'hAB34.
4. WAIT_CYCLES=0, READ_LATENCY=3: four back-to-back reads of addresses 0..3, preloaded 16'h0..16'h3 -> four consecutive strobes starting 3 cycles after first acceptance, data 0,1,2,3.
5. Write address 20'h00405 with MEM_AWIDTH=10, then read address 20'h00005 -> data matches (wrap). Read and write asserted together -> write done, protocol_err=1 and remains set.
6. Read raised, then dropped after 1 stall cycle -> no readdataready, xfer_count unchanged. Assert reset_n low one cycle after a read acceptance with READ_LATENCY=2 -> no strobe ever appears.

Source files
------------

// File: rtl/sram_port_responder_if.sv
// SRAM master-port bundle shared by the tester (master) and the on-chip responder (slave).
// Carries the request, write-data, read-return and stall signals of one port.
interface sram_port_responder_if #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0]   address;
   logic [DATA_WIDTH/8-1:0] byteenable;
   logic                    read;
   logic                    write;
   logic [DATA_WIDTH-1:0]   writedata;
   logic [DATA_WIDTH-1:0]   readdata;
   logic                    readdataready;
   logic                    waitrequest;

   modport master (
      output address, byteenable, read, write, writedata,
      input  readdata, readdataready, waitrequest
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output readdata, readdataready, waitrequest
   );
endinterface

// File: rtl/sram_port_responder.sv
// On-chip memory responder for the tester SRAM port: fixed wait states per transfer,
// byte-lane writes and a non-stalling read-return pipeline of READ_LATENCY stages.
module sram_port_responder #(
   parameter int ADDR_WIDTH   = 20,
   parameter int DATA_WIDTH   = 16,
   parameter int MEM_AWIDTH   = 10,
   parameter int WAIT_CYCLES  = 2,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   sram_port_responder_if.slave  bus,
   output logic [15:0]           xfer_count,
   output logic                  protocol_err
);

   localparam int         NUM_BYTES = DATA_WIDTH / 8;
   localparam int         DEPTH     = 2 ** MEM_AWIDTH;
   localparam logic [3:0] WAIT_VAL  = 4'(WAIT_CYCLES);

   logic [3:0]            r_wcnt;
   logic [3:0]            w_wcnt_nxt;
   logic                  w_req;
   logic                  w_wait;
   logic                  w_accept;
   logic                  w_do_write;
   logic                  w_do_read;
   logic [MEM_AWIDTH-1:0] w_idx;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic                  w_unused_addr;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  r_pv  [READ_LATENCY];
   logic [DATA_WIDTH-1:0] r_pd  [READ_LATENCY];
   logic [15:0]           r_xfer;
   logic                  r_perr;

   // Request decode, stall generation and wait-counter next value
   always_comb begin
      w_req         = bus.read | bus.write;
      w_wait        = !reset_n | (w_req & (r_wcnt != WAIT_VAL));
      w_accept      = w_req & !w_wait;
      w_do_write    = w_accept & bus.write;
      w_do_read     = w_accept & bus.read & !bus.write;
      w_idx         = bus.address[MEM_AWIDTH-1:0];
      w_rd_word     = r_mem[w_idx];
      w_unused_addr = ^bus.address;
      w_wcnt_nxt    = r_wcnt;
      // A dropped request abandons its partial wait so the next one starts fresh
      if (w_accept || !w_req) begin
         w_wcnt_nxt = 4'd0;
      end else if (r_wcnt != 4'hF) begin
         w_wcnt_nxt = r_wcnt + 4'd1;
      end else begin
         w_wcnt_nxt = r_wcnt;
      end
   end

   // Wait-state counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wcnt <= 4'd0;
      end else begin
         r_wcnt <= w_wcnt_nxt;
      end
   end

   // Memory array with per-lane write enables; contents survive reset
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (w_do_write && bus.byteenable[i]) begin
            r_mem[w_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
         end
      end
   end

   // Read-return pipeline; data is zeroed in empty slots so readdata idles at 0
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_pv[i] <= 1'b0;
            r_pd[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         r_pv[0] <= w_do_read;
         r_pd[0] <= w_do_read ? w_rd_word : {DATA_WIDTH{1'b0}};
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pd[i] <= r_pd[i-1];
         end
      end
   end

   // Saturating transfer counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_xfer <= 16'd0;
      end else if (w_accept && (r_xfer != 16'hFFFF)) begin
         r_xfer <= r_xfer + 16'd1;
      end
   end

   // Sticky flag for read and write raised together
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_perr <= 1'b0;
      end else if (bus.read && bus.write) begin
         r_perr <= 1'b1;
      end
   end

   assign bus.waitrequest   = w_wait;
   assign bus.readdata      = r_pd[READ_LATENCY-1];
   assign bus.readdataready = r_pv[READ_LATENCY-1];
   assign xfer_count        = r_xfer;
   assign protocol_err      = r_perr;

endmodule
